// File: rtl/rf_pkg.sv
// Shared sizing constants for the reg_file_sb register file and its scoreboard.
package rf_pkg;
    localparam int RF_DW       = 32;
    localparam int RF_AW       = 5;
    localparam int RF_NREG     = 32;
    localparam int RF_CNT_W    = 2;
    localparam int RF_ZERO_REG = 0;
    localparam int RF_CNT_MAX  = (1 << RF_CNT_W) - 1;
endpackage

// File: rtl/reg_file_sb_if.sv
// Write-back, read and issue signals of reg_file_sb; master drives requests, slave is the register file.
interface reg_file_sb_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DW,
    parameter int AW     = RF_AW
);
    logic              wb_en_i;
    logic [AW-1:0]     wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              rd_en_i;
    logic [AW-1:0]     ra_addr_i;
    logic [AW-1:0]     rb_addr_i;
    logic [DATA_W-1:0] ra_data_o;
    logic [DATA_W-1:0] rb_data_o;
    logic              rd_valid_o;
    logic              hazard_o;
    logic              iss_en_i;
    logic [AW-1:0]     iss_addr_i;
    logic              iss_full_o;

    modport master (
        output wb_en_i, wb_addr_i, wb_data_i, rd_en_i, ra_addr_i, rb_addr_i,
               iss_en_i, iss_addr_i,
        input  ra_data_o, rb_data_o, rd_valid_o, hazard_o, iss_full_o
    );

    modport slave (
        input  wb_en_i, wb_addr_i, wb_data_i, rd_en_i, ra_addr_i, rb_addr_i,
               iss_en_i, iss_addr_i,
        output ra_data_o, rb_data_o, rd_valid_o, hazard_o, iss_full_o
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters; flags operand hazards and saturated destinations.
// Macro RF_WR_BYPASS_EN exempts a source whose last pending write completes this cycle.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG  = RF_NREG,
    parameter int AW    = RF_AW,
    parameter int CNT_W = RF_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_en_i,
    input  logic [AW-1:0] iss_addr_i,
    input  logic          wb_en_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [AW-1:0] ra_addr_i,
    input  logic [AW-1:0] rb_addr_i,
    output logic          hazard_o,
    output logic          iss_full_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             iss_ok, wb_ok, same_reg;
    logic             byp_a, byp_b, haz_a, haz_b;

    always_comb begin
        cnt_d    = cnt_q;
        iss_ok   = iss_en_i && (iss_addr_i != '0) && (cnt_q[iss_addr_i] != CNT_MAX);
        wb_ok    = wb_en_i && (wb_addr_i != '0) && (cnt_q[wb_addr_i] != '0);
        same_reg = iss_en_i && wb_en_i && (iss_addr_i == wb_addr_i);
        // An issue and a completion on one register cancel out.
        if (!same_reg) begin
            if (iss_ok) cnt_d[iss_addr_i] = cnt_q[iss_addr_i] + 1'b1;
            if (wb_ok)  cnt_d[wb_addr_i]  = cnt_q[wb_addr_i] - 1'b1;
        end
    end

    always_comb begin
`ifdef RF_WR_BYPASS_EN
        byp_a = wb_en_i && (wb_addr_i == ra_addr_i) && (cnt_q[ra_addr_i] == CNT_ONE);
        byp_b = wb_en_i && (wb_addr_i == rb_addr_i) && (cnt_q[rb_addr_i] == CNT_ONE);
`else
        byp_a = 1'b0;
        byp_b = 1'b0;
`endif
        haz_a      = (ra_addr_i != '0) && (cnt_q[ra_addr_i] != '0) && !byp_a;
        haz_b      = (rb_addr_i != '0) && (cnt_q[rb_addr_i] != '0) && !byp_b;
        hazard_o   = haz_a || haz_b;
        iss_full_o = (iss_addr_i != '0) && (cnt_q[iss_addr_i] == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '{default: '0};
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write architectural register file with a pending-write scoreboard.
// Macro RF_WR_BYPASS_EN makes a same-cycle write visible to the read ports.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DW,
    parameter int NREG   = RF_NREG,
    parameter int AW     = RF_AW,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] ra_data_q, ra_data_d, rb_data_q, rb_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] ra_val, rb_val;
    logic              wb_live;

    always_comb begin
        wb_live = bus.wb_en_i && (bus.wb_addr_i != AW'(RF_ZERO_REG));
        regs_d  = regs_q;
        if (wb_live) regs_d[bus.wb_addr_i] = bus.wb_data_i;

        ra_val = (bus.ra_addr_i == AW'(RF_ZERO_REG)) ? '0 : regs_q[bus.ra_addr_i];
        rb_val = (bus.rb_addr_i == AW'(RF_ZERO_REG)) ? '0 : regs_q[bus.rb_addr_i];
`ifdef RF_WR_BYPASS_EN
        if (wb_live && (bus.wb_addr_i == bus.ra_addr_i)) ra_val = bus.wb_data_i;
        if (wb_live && (bus.wb_addr_i == bus.rb_addr_i)) rb_val = bus.wb_data_i;
`endif
        ra_data_d  = bus.rd_en_i ? ra_val : ra_data_q;
        rb_data_d  = bus.rd_en_i ? rb_val : rb_data_q;
        rd_valid_d = bus.rd_en_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            ra_data_q  <= '0;
            rb_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            ra_data_q  <= ra_data_d;
            rb_data_q  <= rb_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.ra_data_o  = ra_data_q;
    assign bus.rb_data_o  = rb_data_q;
    assign bus.rd_valid_o = rd_valid_q;

    rf_scoreboard #(
        .NREG  (NREG),
        .AW    (AW),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_en_i   (bus.iss_en_i),
        .iss_addr_i (bus.iss_addr_i),
        .wb_en_i    (bus.wb_en_i),
        .wb_addr_i  (bus.wb_addr_i),
        .ra_addr_i  (bus.ra_addr_i),
        .rb_addr_i  (bus.rb_addr_i),
        .hazard_o   (bus.hazard_o),
        .iss_full_o (bus.iss_full_o)
    );
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Architectural register file that consumes the write-back stream: write enable, address, and the data word selected at write-back.
- Serves two registered read ports to the decode/operand stage.
- Contains a per-register pending-write scoreboard. Operand reads of registers with in-flight writes are flagged as hazards, so issue can stall.
- Sits between decode/issue (read + issue side) and write-back (write side).

Parameters:
- DATA_W, 32, register width
- NREG, 32, number of architectural registers
- AW, 5, register address width, log2(NREG)
- CNT_W, 2, pending-write counter width per register; max outstanding writes per register = 2^CNT_W-1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- wb_en_i  in  1  write-back valid
- wb_addr_i  in  AW  write-back destination register
- wb_data_i  in  DATA_W  write-back data
- rd_en_i  in  1  read request, both ports
- ra_addr_i  in  AW  port A source register
- rb_addr_i  in  AW  port B source register
- ra_data_o  out  DATA_W  port A data, registered
- rb_data_o  out  DATA_W  port B data, registered
- rd_valid_o  out  1  read data valid, one cycle after rd_en_i
- hazard_o  out  1  combinational: ra or rb has an unresolved pending write
- iss_en_i  in  1  issue of an instruction that will write iss_addr_i
- iss_addr_i  in  AW  destination register of issued instruction
- iss_full_o  out  1  combinational: pending counter of iss_addr_i saturated

Behaviour:
- Reset (rst_n low at clk edge): all registers, all pending counters, ra_data_o, rb_data_o and rd_valid_o cleared to 0. Applies mid-operation; in-flight issues are discarded.
- Register 0 is hardwired zero:
  - writes to it are ignored
  - reads return 0
  - it never becomes pending
  - it never raises hazard_o or iss_full_o
- Write: wb_en_i=1 and wb_addr_i!=0 -> regs[wb_addr_i] <= wb_data_i at the clk edge.
- Read:
  - rd_en_i=1 in cycle N -> ra_data_o/rb_data_o updated at the edge ending N; rd_valid_o=1 in N+1.
  - rd_en_i=0 -> data outputs hold; rd_valid_o=0 next cycle.
- Scoreboard: cnt[r] per register.
  - iss_en_i only, iss_addr_i!=0, cnt<max -> cnt+1.
  - wb_en_i only -> cnt-1, saturating at 0; write still performed.
  - Both on the same register in the same cycle -> cnt unchanged.
  - Both on different registers -> both updates apply.
  - iss_en_i while iss_full_o=1 -> issue ignored, cnt unchanged. Upstream must stall on iss_full_o.
- hazard_o per source port (address X = ra_addr_i or rb_addr_i): port hazard = X!=0 and cnt[X]!=0, minus the bypass exemption below. hazard_o = OR of both ports. It is evaluated whether or not rd_en_i is asserted.
- ra_addr_i == rb_addr_i: both ports return identical data.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined:
  - A read in the same cycle as a write to the same non-zero register returns wb_data_i (write-through).
  - A port whose address has cnt==1 and matches wb_addr_i with wb_en_i=1 is not counted as a hazard.
- Undefined:
  - Reads return the pre-write register value.
  - hazard_o is raised whenever cnt!=0, including the completing cycle. The consumer retries one cycle later.

Decomposition:
- Package rf_pkg holds RF_DW, RF_AW, RF_NREG, RF_CNT_W, RF_ZERO_REG (=0), and a derived RF_CNT_MAX.
- One sub-module, rf_scoreboard, owns:
  - the counter array
  - iss/wb update rules
  - hazard_o and iss_full_o generation
- reg_file_sb keeps the storage array, the read registers and the bypass mux.

Test Plan:
- Basic write/read: wb r5=0xDEADBEEF; next cycle rd_en with ra=5, rb=0 -> next cycle ra_data=0xDEADBEEF, rb_data=0, rd_valid=1.
- Same-cycle write and read of r7 (old value 0x1, wb_data 0x2):
  - with RF_WR_BYPASS_EN: ra_data=0x2
  - without it: ra_data=0x1; next-cycle re-read gives 0x2
- Scoreboard and hazard:
  - iss r3 twice, then ra=3 -> hazard_o=1.
  - wb r3 once -> hazard_o stays 1.
  - Second wb r3: hazard_o=1 in the wb cycle only without bypass; 0 with bypass. After the wb edge, hazard_o=0.
- Saturation: iss r9 three times -> iss_full_o=1 for iss_addr=9. Fourth iss is ignored, and exactly three wb r9 return cnt to 0.
- Simultaneous iss and wb on r4 with cnt=1 -> cnt stays 1, hazard on ra=4 persists. Writes to r0 with 0xFFFF_FFFF -> reads of r0 return 0, and iss r0 never asserts hazard.
- Reset mid-operation: with pending r2 and data in r6, assert rst_n=0 for one edge -> all outputs 0, r6 reads 0, hazard_o=0 for ra=2.
